// File: rtl/mem_bus_arbiter.sv
// Two-to-one memory bus arbiter: merges the instruction-fetch port and the
// data port onto a single memory port, one transaction in flight at a time.
module mem_bus_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ireq_valid,
  output logic        ireq_ready,
  input  logic [31:0] ireq_addr,
  input  logic        ireq_wen,
  input  logic [31:0] ireq_wdata,
  output logic        iresp_valid,
  output logic        iresp_error,
  output logic [1:0]  iresp_errty,
  output logic [31:0] iresp_rdata,

  input  logic        dreq_valid,
  output logic        dreq_ready,
  input  logic [31:0] dreq_addr,
  input  logic        dreq_wen,
  input  logic [31:0] dreq_wdata,
  output logic        dresp_valid,
  output logic        dresp_error,
  output logic [1:0]  dresp_errty,
  output logic [31:0] dresp_rdata,

  output logic        memreq_valid,
  input  logic        memreq_ready,
  output logic [31:0] memreq_addr,
  output logic        memreq_wen,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_valid,
  input  logic        memresp_error,
  input  logic [1:0]  memresp_errty,
  input  logic [31:0] memresp_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t      state_q, state_d;
  port_t       owner_q, owner_d;
  port_t       last_q, last_d;
  port_t       sel;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;

  // Pick the candidate port: a lone requester wins; ties go round-robin or to D.
  always_comb begin
    sel = PORT_I;
    if (ireq_valid && dreq_valid) begin
      if (RR != 0) sel = (last_q == PORT_I) ? PORT_D : PORT_I;
      else         sel = PORT_D;
    end else if (dreq_valid) begin
      sel = PORT_D;
    end
  end

  // Next-state, request latch and handshake outputs; everything idles in reset.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    ireq_ready   = 1'b0;
    dreq_ready   = 1'b0;
    memreq_valid = 1'b0;
    iresp_valid  = 1'b0;
    dresp_valid  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          ireq_ready = ireq_valid && (sel == PORT_I);
          dreq_ready = dreq_valid && (sel == PORT_D);
          if ((ireq_valid && (sel == PORT_I)) || (dreq_valid && (sel == PORT_D))) begin
            owner_d = sel;
            last_d  = sel;
            addr_d  = (sel == PORT_D) ? dreq_addr  : ireq_addr;
            wen_d   = (sel == PORT_D) ? dreq_wen   : ireq_wen;
            wdata_d = (sel == PORT_D) ? dreq_wdata : ireq_wdata;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          memreq_valid = 1'b1;
          if (memreq_ready) state_d = WAIT;
        end
        WAIT: begin
          if (memresp_valid) begin
            iresp_valid = (owner_q == PORT_I);
            dresp_valid = (owner_q == PORT_D);
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      last_q  <= PORT_D;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign memreq_addr  = addr_q;
  assign memreq_wen   = wen_q;
  assign memreq_wdata = wdata_q;

  // Response payload passes straight through; only the valids are steered.
  assign iresp_error  = memresp_error;
  assign iresp_errty  = memresp_errty;
  assign iresp_rdata  = memresp_rdata;
  assign dresp_error  = memresp_error;
  assign dresp_errty  = memresp_errty;
  assign dresp_rdata  = memresp_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: stimulus plans transactions, a memory model answers them,
// a response monitor pops expected results and compares.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          port;   // 0 = I, 1 = D
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  ety;
    int          stall;
    bit          drop;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        ireq_valid, ireq_wen, dreq_valid, dreq_wen;
  logic [31:0] ireq_addr, ireq_wdata, dreq_addr, dreq_wdata;
  logic        memreq_ready, memresp_valid, memresp_error;
  logic [1:0]  memresp_errty;
  logic [31:0] memresp_rdata;

  logic        ireq_ready_a [2], dreq_ready_a [2];
  logic        iresp_valid_a [2], iresp_error_a [2], dresp_valid_a [2], dresp_error_a [2];
  logic [1:0]  iresp_errty_a [2], dresp_errty_a [2];
  logic [31:0] iresp_rdata_a [2], dresp_rdata_a [2];
  logic        memreq_valid_a [2], memreq_wen_a [2];
  logic [31:0] memreq_addr_a [2], memreq_wdata_a [2];

  logic        ireq_ready, dreq_ready, iresp_valid, iresp_error, dresp_valid, dresp_error;
  logic [1:0]  iresp_errty, dresp_errty;
  logic [31:0] iresp_rdata, dresp_rdata;
  logic        memreq_valid, memreq_wen;
  logic [31:0] memreq_addr, memreq_wdata;

  assign ireq_ready   = ireq_ready_a[sel];
  assign dreq_ready   = dreq_ready_a[sel];
  assign iresp_valid  = iresp_valid_a[sel];
  assign iresp_error  = iresp_error_a[sel];
  assign iresp_errty  = iresp_errty_a[sel];
  assign iresp_rdata  = iresp_rdata_a[sel];
  assign dresp_valid  = dresp_valid_a[sel];
  assign dresp_error  = dresp_error_a[sel];
  assign dresp_errty  = dresp_errty_a[sel];
  assign dresp_rdata  = dresp_rdata_a[sel];
  assign memreq_valid = memreq_valid_a[sel];
  assign memreq_wen   = memreq_wen_a[sel];
  assign memreq_addr  = memreq_addr_a[sel];
  assign memreq_wdata = memreq_wdata_a[sel];

  mem_bus_arbiter #(.RR(1)) u_rr (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready_a[0]), .ireq_addr(ireq_addr),
    .ireq_wen(ireq_wen), .ireq_wdata(ireq_wdata),
    .iresp_valid(iresp_valid_a[0]), .iresp_error(iresp_error_a[0]),
    .iresp_errty(iresp_errty_a[0]), .iresp_rdata(iresp_rdata_a[0]),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready_a[0]), .dreq_addr(dreq_addr),
    .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid_a[0]), .dresp_error(dresp_error_a[0]),
    .dresp_errty(dresp_errty_a[0]), .dresp_rdata(dresp_rdata_a[0]),
    .memreq_valid(memreq_valid_a[0]), .memreq_ready(memreq_ready),
    .memreq_addr(memreq_addr_a[0]), .memreq_wen(memreq_wen_a[0]), .memreq_wdata(memreq_wdata_a[0]),
    .memresp_valid(memresp_valid), .memresp_error(memresp_error),
    .memresp_errty(memresp_errty), .memresp_rdata(memresp_rdata)
  );

  mem_bus_arbiter #(.RR(0)) u_fp (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready_a[1]), .ireq_addr(ireq_addr),
    .ireq_wen(ireq_wen), .ireq_wdata(ireq_wdata),
    .iresp_valid(iresp_valid_a[1]), .iresp_error(iresp_error_a[1]),
    .iresp_errty(iresp_errty_a[1]), .iresp_rdata(iresp_rdata_a[1]),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready_a[1]), .dreq_addr(dreq_addr),
    .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid_a[1]), .dresp_error(dresp_error_a[1]),
    .dresp_errty(dresp_errty_a[1]), .dresp_rdata(dresp_rdata_a[1]),
    .memreq_valid(memreq_valid_a[1]), .memreq_ready(memreq_ready),
    .memreq_addr(memreq_addr_a[1]), .memreq_wen(memreq_wen_a[1]), .memreq_wdata(memreq_wdata_a[1]),
    .memresp_valid(memresp_valid), .memresp_error(memresp_error),
    .memresp_errty(memresp_errty), .memresp_rdata(memresp_rdata)
  );

  txn_t plan [$];
  txn_t exp_resp [$];
  int   n_chk = 0, n_err = 0, n_planned = 0, n_resp_seen = 0;
  txn_t mt, mon;
  bit   stray;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic plan_txn(input bit p, input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [31:0] rd, input logic er, input logic [1:0] et,
                          input int st, input bit dr);
    txn_t t;
    t.port = p; t.addr = a; t.wen = w; t.wdata = wd; t.rdata = rd;
    t.err = er; t.ety = et; t.stall = st; t.drop = dr;
    plan.push_back(t);
    if (!dr) n_planned++;
  endtask

  // Raise a request and hold it until accepted; returns #1 after the accept edge.
  task automatic req(input bit p, input logic [31:0] a, input logic w, input logic [31:0] wd);
    bit got = 0;
    if (p) begin dreq_valid = 1; dreq_addr = a; dreq_wen = w; dreq_wdata = wd; end
    else   begin ireq_valid = 1; ireq_addr = a; ireq_wen = w; ireq_wdata = wd; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (p ? dreq_ready : ireq_ready) begin got = 1; break; end
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_timeout: port %0d addr %h never accepted, required acceptance", p, a);
    end
    @(posedge clk); #1;
    if (p) dreq_valid = 0; else ireq_valid = 0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && n_resp_seen != n_planned; k++) @(posedge clk);
    chk(nm, n_resp_seen, n_planned);
    chk({nm, "_plan_empty"}, plan.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  // Memory model: accepts after the planned stall, answers the following cycle.
  initial begin
    memreq_ready = 0; memresp_valid = 0; memresp_error = 0;
    memresp_errty = 0; memresp_rdata = 0;
    forever begin
      @(negedge clk);
      if (memreq_valid && !reset) begin
        stray = (plan.size() == 0);
        if (stray) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_memreq: got addr %h, required no request", memreq_addr);
          mt = '{default: 0};
        end else begin
          mt = plan.pop_front();
        end
        for (int k = 0; k < mt.stall; k++) begin
          chk("stall_addr", memreq_addr, mt.addr);
          chk("stall_wen", memreq_wen, mt.wen);
          chk("stall_wdata", memreq_wdata, mt.wdata);
          @(negedge clk);
        end
        if (!stray) begin
          chk("memreq_valid", memreq_valid, 1);
          chk("memreq_addr", memreq_addr, mt.addr);
          chk("memreq_wen", memreq_wen, mt.wen);
          chk("memreq_wdata", memreq_wdata, mt.wdata);
        end
        memreq_ready = 1;
        @(posedge clk); #1 memreq_ready = 0;
        if (mt.drop) begin
          for (int k = 0; k < 50 && !reset; k++) @(negedge clk);
          for (int k = 0; k < 50 && reset; k++) @(negedge clk);
          @(posedge clk); #1;
          memresp_valid = 1; memresp_rdata = 32'hBAD0BAD0; memresp_error = 0; memresp_errty = 0;
        end else begin
          memresp_valid = 1; memresp_rdata = mt.rdata;
          memresp_error = mt.err; memresp_errty = mt.ety;
          if (!stray) exp_resp.push_back(mt);
        end
        @(posedge clk); #1 memresp_valid = 0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (iresp_valid || dresp_valid) begin
      if (exp_resp.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_resp: got iresp_valid=%0d dresp_valid=%0d, required none",
                 iresp_valid, dresp_valid);
      end else begin
        mon = exp_resp.pop_front();
        n_resp_seen++;
        chk("resp_i_valid", iresp_valid, !mon.port);
        chk("resp_d_valid", dresp_valid, mon.port);
        chk("resp_rdata", mon.port ? dresp_rdata : iresp_rdata, mon.rdata);
        chk("resp_error", mon.port ? dresp_error : iresp_error, mon.err);
        chk("resp_errty", mon.port ? dresp_errty : iresp_errty, mon.ety);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; reset = 1;
    ireq_valid = 0; ireq_addr = 0; ireq_wen = 0; ireq_wdata = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_wen = 0; dreq_wdata = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset: no ready or valid even with both requesters active.
    ireq_valid = 1; dreq_valid = 1;
    @(negedge clk);
    chk("rst_ireq_ready", ireq_ready, 0);
    chk("rst_dreq_ready", dreq_ready, 0);
    chk("rst_memreq_valid", memreq_valid, 0);
    chk("rst_iresp_valid", iresp_valid, 0);
    chk("rst_dresp_valid", dresp_valid, 0);
    chk("rst_memreq_addr", memreq_addr, 0);
    @(posedge clk); #1;
    ireq_valid = 0; dreq_valid = 0; reset = 0;

    // Single I read with minimum latency.
    plan_txn(0, 32'h1000, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    req(0, 32'h1000, 0, 0);
    @(negedge clk);
    chk("t1_memreq_valid", memreq_valid, 1);
    chk("t1_memreq_addr", memreq_addr, 32'h1000);
    chk("t1_ireq_ready_issue", ireq_ready, 0);
    @(negedge clk);
    chk("t1_iresp_valid", iresp_valid, 1);
    chk("t1_dresp_valid", dresp_valid, 0);
    drain("t1_drain");

    // Round-robin after reset: I, D, I, D.
    do_reset();
    plan_txn(0, 32'h0100, 0, 0, 32'hA0000001, 0, 0, 0, 0);
    plan_txn(1, 32'h0200, 0, 0, 32'hB0000001, 0, 0, 0, 0);
    plan_txn(0, 32'h0104, 0, 0, 32'hA0000002, 0, 0, 0, 0);
    plan_txn(1, 32'h0204, 0, 0, 32'hB0000002, 0, 0, 0, 0);
    fork
      begin req(0, 32'h0100, 0, 0); req(0, 32'h0104, 0, 0); end
      begin req(1, 32'h0200, 0, 0); req(1, 32'h0204, 0, 0); end
    join
    drain("rr_drain");

    // Stalled D store: fields held for 5 cycles.
    plan_txn(1, 32'h2004, 1, 32'h12345678, 32'h0, 0, 0, 5, 0);
    req(1, 32'h2004, 1, 32'h12345678);
    drain("stall_drain");

    // D read with error, then back-to-back I accepted on return to IDLE.
    plan_txn(1, 32'h7000, 0, 0, 32'h0, 1, 2'd2, 0, 0);
    plan_txn(0, 32'h7100, 0, 0, 32'h11112222, 0, 0, 0, 0);
    req(1, 32'h7000, 0, 0);
    ireq_valid = 1; ireq_addr = 32'h7100; ireq_wen = 0; ireq_wdata = 0;
    @(negedge clk);
    chk("b2b_ready_issue", ireq_ready, 0);
    @(negedge clk);
    chk("err_dresp_valid", dresp_valid, 1);
    chk("err_dresp_error", dresp_error, 1);
    chk("err_dresp_errty", dresp_errty, 2);
    chk("b2b_ready_wait", ireq_ready, 0);
    @(negedge clk);
    chk("b2b_ready_idle", ireq_ready, 1);
    @(posedge clk); #1 ireq_valid = 0;
    drain("err_drain");

    // D request withdrawn while I is in flight is never issued.
    plan_txn(0, 32'h3000, 0, 0, 32'h33333333, 0, 0, 0, 0);
    req(0, 32'h3000, 0, 0);
    dreq_valid = 1; dreq_addr = 32'h4000; dreq_wen = 1; dreq_wdata = 32'h44444444;
    @(negedge clk);
    chk("wd_dready_issue", dreq_ready, 0);
    @(negedge clk);
    chk("wd_dready_wait", dreq_ready, 0);
    @(posedge clk); #1 dreq_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    drain("wd_drain");

    // Reset in WAIT abandons the transaction; stale response is ignored.
    plan_txn(0, 32'h5000, 0, 0, 32'h0, 0, 0, 0, 1);
    req(0, 32'h5000, 0, 0);
    @(posedge clk); #1;
    reset = 1; ireq_valid = 1; dreq_valid = 1;
    @(negedge clk);
    chk("rw_rst_ireq_ready", ireq_ready, 0);
    chk("rw_rst_dreq_ready", dreq_ready, 0);
    chk("rw_rst_memreq_valid", memreq_valid, 0);
    @(posedge clk); #1;
    reset = 0; ireq_valid = 0; dreq_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rw_ghost_iresp", iresp_valid, 0);
      chk("rw_ghost_dresp", dresp_valid, 0);
    end
    @(posedge clk); #1;
    plan_txn(0, 32'h6000, 0, 0, 32'h600DF00D, 0, 0, 0, 0);
    req(0, 32'h6000, 0, 0);
    drain("rw_drain");

    // Fixed priority instance: D wins three times, then I.
    sel = 1;
    do_reset();
    plan_txn(1, 32'h0300, 0, 0, 32'hD0000001, 0, 0, 0, 0);
    plan_txn(1, 32'h0304, 0, 0, 32'hD0000002, 0, 0, 0, 0);
    plan_txn(1, 32'h0308, 0, 0, 32'hD0000003, 0, 0, 0, 0);
    plan_txn(0, 32'h0310, 0, 0, 32'hC0000001, 0, 0, 0, 0);
    fork
      begin req(0, 32'h0310, 0, 0); end
      begin req(1, 32'h0300, 0, 0); req(1, 32'h0304, 0, 0); req(1, 32'h0308, 0, 0); end
    join
    drain("fp_drain");

    chk("final_resp_queue_empty", exp_resp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
